// File: rtl/onchip_mem_loader_pkg.sv
// Shared definitions for the on-chip memory stream loader.
// Holds the memory geometry, the byte-lane mask constants and the
// loader state encoding used by the top-level FSM.
package onchip_mem_loader_pkg;

  localparam int ADDR_W    = 11;
  localparam int MEM_WORDS = 1860;
  localparam int CNT_W     = 12;

  // Byte-lane masks: only the low lane, or both lanes of a 16-bit word.
  localparam logic [1:0] BE_LO  = 2'b01;
  localparam logic [1:0] BE_ALL = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RX_LO = 3'd1,
    RX_HI = 3'd2,
    WR    = 3'd3,
    VA    = 3'd4,
    VC    = 3'd5,
    FIN   = 3'd6
  } loader_state_t;

  // Expands a 2-bit byte enable into a 16-bit data mask.
  function automatic logic [15:0] lane_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/loader_byte_packer.sv
// Byte-stream front end of the loader.
// Performs the valid/ready handshake, packs bytes little-endian into a
// 16-bit lane buffer and flags the final byte of the programmed count.
//
// Ports:
//   clk, reset_n     - clock and synchronous active-low reset
//   load             - accepted start; loads byte_count, clears the buffer
//   byte_count       - number of bytes in this transfer
//   rx_lo, rx_hi     - FSM is waiting for the low / high byte of a word
//   in_data/in_valid - upstream byte stream
//   in_ready         - a byte is accepted this cycle when in_valid is high
//   byte_fire        - handshake completed this cycle
//   last_byte        - the byte taken this cycle is the final one
//   word_data        - packed word (high lane zero for a lone low byte)
//   word_be          - byte enable matching word_data
module loader_byte_packer #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] byte_count,
  input  logic             rx_lo,
  input  logic             rx_hi,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             byte_fire,
  output logic             last_byte,
  output logic [15:0]      word_data,
  output logic [1:0]       word_be
);
  import onchip_mem_loader_pkg::*;

  logic [CNT_W-1:0] bytes_left;
  logic [15:0]      lane_buf;
  logic [1:0]       be_q;

  assign in_ready  = rx_lo | rx_hi;
  assign byte_fire = in_ready & in_valid;
  assign last_byte = byte_fire && (bytes_left == CNT_W'(1));
  assign word_data = lane_buf;
  assign word_be   = be_q;

  // A low byte always clears the high lane so an odd trailing byte is
  // written as 0x00nn with only the low lane enabled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bytes_left <= '0;
      lane_buf   <= '0;
      be_q       <= '0;
    end else if (load) begin
      bytes_left <= byte_count;
      lane_buf   <= '0;
      be_q       <= '0;
    end else if (byte_fire) begin
      bytes_left <= bytes_left - 1'b1;
      if (rx_lo) begin
        lane_buf <= {8'h00, in_data};
        be_q     <= BE_LO;
      end else begin
        lane_buf[15:8] <= in_data;
        be_q           <= BE_ALL;
      end
    end
  end

endmodule

// File: rtl/onchip_mem_stream_loader.sv
// Boot-time loader that streams bytes into the single-port on-chip memory.
// Bytes are packed little-endian into 16-bit words, written from a
// programmed base address, then read back and checked against the running
// checksum of what was written.
//
// Ports:
//   clk, reset_n          - clock and synchronous active-low reset
//   start                 - one-cycle pulse; ignored while busy
//   base_addr, byte_count - transfer parameters latched on start
//   in_data/in_valid/in_ready - byte stream handshake
//   mem_*                 - memory master interface (readdata has 1-cycle latency)
//   busy                  - operation in progress
//   done, error           - sticky status, cleared by the next accepted start
//   checksum              - sum mod 2^16 of the lane-masked words written
module onchip_mem_stream_loader #(
  parameter int ADDR_W    = 11,
  parameter int MEM_WORDS = 1860,
  parameter int CNT_W     = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [1:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [15:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [15:0]       mem_readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       checksum
);
  import onchip_mem_loader_pkg::*;

  loader_state_t     state_q;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  words_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic              odd_q;
  logic [15:0]       checksum_q;
  logic [15:0]       verify_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;

  logic              start_accept;
  logic              byte_fire;
  logic              last_byte;
  logic [15:0]       word_data;
  logic [1:0]        word_be;
  logic [CNT_W-1:0]  words_calc;
  logic [CNT_W:0]    range_end;
  logic              range_bad;
  logic [ADDR_W-1:0] word_idx_next;
  logic              last_word;
  logic [15:0]       verify_mask;
  logic [15:0]       verify_next;
  logic              in_access;

  assign start_accept = (state_q == IDLE) && start;

  // ceil(byte_count/2) without needing an extra carry bit.
  assign words_calc = {1'b0, byte_count[CNT_W-1:1]} + CNT_W'(byte_count[0]);

  // One bit wider than the count so base+words cannot overflow the check.
  assign range_end = (CNT_W+1)'(base_addr) + (CNT_W+1)'(words_calc);
  assign range_bad = range_end > (CNT_W+1)'(MEM_WORDS);

  // Word index never exceeds MEM_WORDS thanks to the range check, so the
  // address-width counter cannot wrap.
  assign word_idx_next = word_idx_q + 1'b1;
  assign last_word     = (CNT_W'(word_idx_next) == words_q);

  // The trailing word of an odd-length load only owns its low byte; the
  // memory's high byte is whatever was there before and must be ignored.
  assign verify_mask = (last_word && odd_q) ? lane_mask(BE_LO) : lane_mask(BE_ALL);
  assign verify_next = verify_q + (mem_readdata & verify_mask);

  loader_byte_packer #(
    .CNT_W (CNT_W)
  ) u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (start_accept),
    .byte_count (byte_count),
    .rx_lo      (state_q == RX_LO),
    .rx_hi      (state_q == RX_HI),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .byte_fire  (byte_fire),
    .last_byte  (last_byte),
    .word_data  (word_data),
    .word_be    (word_be)
  );

  // Main sequencer: receive bytes, write one word per WR cycle, then a
  // two-cycle-per-word read-back that rebuilds the checksum for comparison.
  // Empty or out-of-range requests go straight to FIN without touching memory.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      words_q    <= '0;
      word_idx_q <= '0;
      odd_q      <= 1'b0;
      checksum_q <= '0;
      verify_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            words_q    <= words_calc;
            odd_q      <= byte_count[0];
            word_idx_q <= '0;
            checksum_q <= '0;
            verify_q   <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= (byte_count != '0) && range_bad;
            if ((byte_count == '0) || range_bad) begin
              state_q <= FIN;
            end else begin
              state_q <= RX_LO;
            end
          end
        end
        RX_LO: begin
          if (byte_fire) begin
            state_q <= last_byte ? WR : RX_HI;
          end
        end
        RX_HI: begin
          if (byte_fire) begin
            state_q <= WR;
          end
        end
        WR: begin
          checksum_q <= checksum_q + (word_data & lane_mask(word_be));
          if (last_word) begin
            word_idx_q <= '0;
            state_q    <= VA;
          end else begin
            word_idx_q <= word_idx_next;
            state_q    <= RX_LO;
          end
        end
        VA: begin
          state_q <= VC;
        end
        VC: begin
          verify_q <= verify_next;
          if (last_word) begin
            error_q <= error_q | (verify_next != checksum_q);
            state_q <= FIN;
          end else begin
            word_idx_q <= word_idx_next;
            state_q    <= VA;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory strobes decode straight from state so a reset drops them on the
  // very next cycle; address and data read as zero when not selected.
  assign in_access      = (state_q == WR) || (state_q == VA) || (state_q == VC);
  assign mem_chipselect = in_access;
  assign mem_write      = (state_q == WR);
  assign mem_address    = in_access ? (base_q + word_idx_q) : '0;
  assign mem_writedata  = (state_q == WR) ? word_data : 16'h0000;
  assign mem_byteenable = (state_q == WR) ? word_be : (in_access ? BE_ALL : 2'b00);
  assign mem_clken      = 1'b1;

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign checksum = checksum_q;

endmodule

// File: tb/tb_onchip_mem_stream_loader.sv
// Directed self-checking bench for onchip_mem_stream_loader.
// Includes a 2048-word memory model with one-cycle read latency, a write
// logger and an optional single-word read corruption.
module tb_onchip_mem_stream_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] base_addr = '0;
  logic [11:0] byte_count = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] mem_address;
  logic [1:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [15:0] mem_writedata;
  logic        mem_clken;
  logic [15:0] mem_readdata = '0;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] checksum;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem_model [0:2047];
  logic [10:0] wr_addr_log [0:255];
  logic [15:0] wr_data_log [0:255];
  logic [1:0]  wr_be_log [0:255];
  int          wr_cnt = 0;
  int          cs_cnt = 0;
  int          rd_cnt = 0;
  logic        corrupt_en = 1'b0;
  logic [10:0] corrupt_addr = '0;

  onchip_mem_stream_loader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .byte_count     (byte_count),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .checksum       (checksum)
  );

  always #5 clk = ~clk;

  // Memory model and bus monitor.
  always @(posedge clk) begin
    if (mem_chipselect) cs_cnt++;
    if (mem_chipselect && mem_write) begin
      if (wr_cnt < 256) begin
        wr_addr_log[wr_cnt] = mem_address;
        wr_data_log[wr_cnt] = mem_writedata;
        wr_be_log[wr_cnt]   = mem_byteenable;
      end
      wr_cnt++;
      if (mem_byteenable[0]) mem_model[mem_address][7:0]  = mem_writedata[7:0];
      if (mem_byteenable[1]) mem_model[mem_address][15:8] = mem_writedata[15:8];
    end
    if (mem_chipselect && !mem_write) begin
      rd_cnt++;
      mem_readdata <= mem_model[mem_address] ^
                      ((corrupt_en && mem_address == corrupt_addr) ? 16'h0001 : 16'h0000);
    end
  end

  task automatic pulse_start(input logic [10:0] b, input logic [11:0] c);
    @(negedge clk);
    base_addr  = b;
    byte_count = c;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("[TB] FAIL push_timeout got in_ready=%0b exp=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_done_timeout got=%0b exp=1", name, done);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%0b exp=0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error got=%0b exp=0", error); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes got=%0b%0b exp=00", mem_chipselect, mem_write); end
    checks++; if (mem_clken !== 1'b1) begin errors++; $display("[TB] FAIL reset_clken got=%0b exp=1", mem_clken); end
    checks++; if (checksum !== 16'h0000) begin errors++; $display("[TB] FAIL reset_checksum got=%h exp=0000", checksum); end
    checks++; if (mem_address !== 11'h000) begin errors++; $display("[TB] FAIL reset_address got=%h exp=000", mem_address); end
  endtask

  task automatic test_even_load();
    int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    pulse_start(11'h010, 12'd4);
    push_byte(8'h11, 0); push_byte(8'h22, 0); push_byte(8'h33, 0); push_byte(8'h44, 0);
    wait_done("even");
    checks++; if (wr_cnt - w0 != 2) begin errors++; $display("[TB] FAIL even_wr_count got=%0d exp=2", wr_cnt - w0); end
    checks++; if (wr_addr_log[w0] !== 11'h010 || wr_data_log[w0] !== 16'h2211 || wr_be_log[w0] !== 2'b11) begin
      errors++; $display("[TB] FAIL even_wr0 got=%h/%h/%b exp=010/2211/11", wr_addr_log[w0], wr_data_log[w0], wr_be_log[w0]); end
    checks++; if (wr_addr_log[w0+1] !== 11'h011 || wr_data_log[w0+1] !== 16'h4433 || wr_be_log[w0+1] !== 2'b11) begin
      errors++; $display("[TB] FAIL even_wr1 got=%h/%h/%b exp=011/4433/11", wr_addr_log[w0+1], wr_data_log[w0+1], wr_be_log[w0+1]); end
    checks++; if (checksum !== 16'h6644) begin errors++; $display("[TB] FAIL even_checksum got=%h exp=6644", checksum); end
    checks++; if (rd_cnt - r0 != 4) begin errors++; $display("[TB] FAIL even_read_cycles got=%0d exp=4", rd_cnt - r0); end
    checks++; if (error !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL even_status got err=%0b busy=%0b exp=0/0", error, busy); end
  endtask

  task automatic test_odd_load();
    int w0;
    w0 = wr_cnt;
    pulse_start(11'h010, 12'd3);
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL odd_start_clears got done=%0b busy=%0b exp=0/1", done, busy); end
    push_byte(8'hAA, 1); push_byte(8'hBB, 0); push_byte(8'hCC, 2);
    wait_done("odd");
    checks++; if (wr_cnt - w0 != 2) begin errors++; $display("[TB] FAIL odd_wr_count got=%0d exp=2", wr_cnt - w0); end
    checks++; if (wr_data_log[w0] !== 16'hBBAA || wr_be_log[w0] !== 2'b11) begin errors++; $display("[TB] FAIL odd_wr0 got=%h/%b exp=BBAA/11", wr_data_log[w0], wr_be_log[w0]); end
    checks++; if (wr_addr_log[w0+1] !== 11'h011 || wr_data_log[w0+1] !== 16'h00CC || wr_be_log[w0+1] !== 2'b01) begin
      errors++; $display("[TB] FAIL odd_wr1 got=%h/%h/%b exp=011/00CC/01", wr_addr_log[w0+1], wr_data_log[w0+1], wr_be_log[w0+1]); end
    checks++; if (mem_model[11'h011] !== 16'h44CC) begin errors++; $display("[TB] FAIL odd_mem_word got=%h exp=44CC", mem_model[11'h011]); end
    checks++; if (checksum !== 16'hBC76) begin errors++; $display("[TB] FAIL odd_checksum got=%h exp=BC76", checksum); end
    checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL odd_error got=%0b exp=0", error); end
  endtask

  task automatic test_range();
    int c0, w0;
    c0 = cs_cnt;
    pulse_start(11'd1859, 12'd4);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL range_cycle1 got busy=%0b done=%0b exp=1/0", busy, done); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL range_status got done=%0b err=%0b busy=%0b exp=1/1/0", done, error, busy); end
    checks++; if (cs_cnt != c0) begin errors++; $display("[TB] FAIL range_no_access got=%0d exp=0", cs_cnt - c0); end

    c0 = cs_cnt;
    pulse_start(11'h000, 12'd0);
    @(negedge clk);
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("[TB] FAIL zero_status got done=%0b err=%0b exp=1/0", done, error); end
    checks++; if (cs_cnt != c0) begin errors++; $display("[TB] FAIL zero_no_access got=%0d exp=0", cs_cnt - c0); end

    w0 = wr_cnt;
    pulse_start(11'd1858, 12'd3);
    push_byte(8'h01, 0); push_byte(8'h02, 0); push_byte(8'h03, 0);
    wait_done("edge");
    checks++; if (error !== 1'b0 || wr_cnt - w0 != 2) begin errors++; $display("[TB] FAIL edge_fit got err=%0b writes=%0d exp=0/2", error, wr_cnt - w0); end
    checks++; if (wr_addr_log[w0+1] !== 11'd1859) begin errors++; $display("[TB] FAIL edge_last_addr got=%0d exp=1859", wr_addr_log[w0+1]); end
  endtask

  task automatic test_verify_fail();
    int w0;
    w0 = wr_cnt;
    corrupt_addr = 11'h021;
    corrupt_en   = 1'b1;
    pulse_start(11'h020, 12'd4);
    push_byte(8'h01, 0); push_byte(8'h02, 0); push_byte(8'h03, 0); push_byte(8'h04, 0);
    wait_done("verify");
    corrupt_en = 1'b0;
    checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL verify_error got=%0b exp=1", error); end
    checks++; if (checksum !== 16'h0604) begin errors++; $display("[TB] FAIL verify_checksum got=%h exp=0604", checksum); end
    checks++; if (wr_cnt - w0 != 2) begin errors++; $display("[TB] FAIL verify_wr_count got=%0d exp=2", wr_cnt - w0); end
  endtask

  task automatic test_back_to_back();
    int w0;
    logic [7:0] bytes [0:5];
    bytes[0] = 8'h10; bytes[1] = 8'h20; bytes[2] = 8'h30;
    bytes[3] = 8'h40; bytes[4] = 8'h50; bytes[5] = 8'h60;
    w0 = wr_cnt;
    pulse_start(11'h030, 12'd6);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        base_addr  = 11'h100;
        byte_count = 12'd2;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_restart_ignored got busy=%0b done=%0b exp=1/0", busy, done); end
      end
      push_byte(bytes[i], int'($urandom_range(0, 3)));
    end
    wait_done("b2b");
    checks++; if (wr_cnt - w0 != 3) begin errors++; $display("[TB] FAIL b2b_wr_count got=%0d exp=3", wr_cnt - w0); end
    checks++; if (wr_addr_log[w0] !== 11'h030 || wr_data_log[w0] !== 16'h2010) begin errors++; $display("[TB] FAIL b2b_wr0 got=%h/%h exp=030/2010", wr_addr_log[w0], wr_data_log[w0]); end
    checks++; if (wr_data_log[w0+1] !== 16'h4030) begin errors++; $display("[TB] FAIL b2b_wr1 got=%h exp=4030", wr_data_log[w0+1]); end
    checks++; if (wr_addr_log[w0+2] !== 11'h032 || wr_data_log[w0+2] !== 16'h6050) begin errors++; $display("[TB] FAIL b2b_wr2 got=%h/%h exp=032/6050", wr_addr_log[w0+2], wr_data_log[w0+2]); end
    checks++; if (checksum !== 16'hC090 || error !== 1'b0) begin errors++; $display("[TB] FAIL b2b_checksum got=%h err=%0b exp=C090/0", checksum, error); end
  endtask

  task automatic test_reset_mid_load();
    int w0;
    w0 = wr_cnt;
    pulse_start(11'h040, 12'd4);
    push_byte(8'hA1, 0);
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_status got busy=%0b done=%0b err=%0b rdy=%0b exp=0000", busy, done, error, in_ready); end
    checks++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_clken !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_mem got cs=%0b wr=%0b clken=%0b exp=0/0/1", mem_chipselect, mem_write, mem_clken); end
    reset_n = 1'b1;
    in_data = 8'hB2; in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checks++; if (wr_cnt != w0) begin errors++; $display("[TB] FAIL midreset_no_write got=%0d exp=0", wr_cnt - w0); end
    pulse_start(11'h040, 12'd2);
    push_byte(8'h5A, 0); push_byte(8'hA5, 1);
    wait_done("reload");
    checks++; if (wr_cnt - w0 != 1 || wr_addr_log[w0] !== 11'h040 || wr_data_log[w0] !== 16'hA55A) begin
      errors++; $display("[TB] FAIL reload_write got n=%0d %h/%h exp=1 040/A55A", wr_cnt - w0, wr_addr_log[w0], wr_data_log[w0]); end
    checks++; if (checksum !== 16'hA55A || error !== 1'b0) begin errors++; $display("[TB] FAIL reload_checksum got=%h err=%0b exp=A55A/0", checksum, error); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem_model[i] = 16'h0000;
    test_reset();
    test_even_load();
    test_odd_load();
    test_range();
    test_verify_fail();
    test_back_to_back();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
